// File: rtl/sim_ctrl_pkg.sv
// Register offsets, FSM states and fixed exit codes shared by the
// simulation control responder and its bench.
package sim_ctrl_pkg;

  localparam logic [4:0] OFF_TOHOST   = 5'h00;
  localparam logic [4:0] OFF_CONSOLE  = 5'h04;
  localparam logic [4:0] OFF_CYCLE_LO = 5'h08;
  localparam logic [4:0] OFF_CYCLE_HI = 5'h0C;
  localparam logic [4:0] OFF_STATUS   = 5'h10;

  localparam logic [30:0] EXIT_CODE_TIMEOUT = 31'h7FFF_FFFF;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/sim_ctrl_slave_if.sv
// Data-bus request/response bundle between the core (master) and the
// simulation control responder (slave).
interface sim_ctrl_slave_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/sim_ctrl_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a pop in the same cycle frees a
// slot for a push even when full. Head reads as zero while empty.
module sim_ctrl_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [Width-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [Width-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(Depth):0]   o_count
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] PtrOne = 1;

  logic [Width-1:0] r_mem [Depth];
  logic [AddrW:0]   r_wptr;
  logic [AddrW:0]   r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_count   = r_wptr - r_rptr;
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AddrW] != r_rptr[AddrW]) &&
                     (r_wptr[AddrW-1:0] == r_rptr[AddrW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = o_empty ? '0 : r_mem[r_rptr[AddrW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PtrOne;
      if (w_do_pop)  r_rptr <= r_rptr + PtrOne;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AddrW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/sim_ctrl_slave.sv
// Memory-mapped test-harness responder: TOHOST end-of-test, console FIFO,
// 64-bit cycle counter and optional watchdog.
module sim_ctrl_slave
  import sim_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT     = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  sim_ctrl_slave_if.slave   bus,
  output logic              o_con_valid,
  output logic [7:0]        o_con_data,
  input  logic              i_con_ready,
  output logic              o_done,
  output logic              o_pass,
  output logic [30:0]       o_exit_code
);

  localparam int unsigned CntW     = $clog2(FIFO_DEPTH) + 1;
  localparam bit          WdogEn   = (TIMEOUT != 0);
  localparam logic [63:0] WdogLast = 64'(TIMEOUT) - 64'd1;
  localparam logic [3:0]  WaitLast = 4'(WAIT_CYCLES - 1);

  state_e      r_state, w_state_next;
  logic [3:0]  r_wait_cnt, w_wait_cnt_next;
  logic [63:0] r_cycle;
  logic [31:0] r_snap;
  logic        r_done, r_pass, r_timeout;
  logic [30:0] r_exit;
  logic [31:0] r_rdata;
  logic        r_err;

  logic            w_accept, w_in_region;
  logic [4:0]      w_off;
  logic [31:0]     w_rdata;
  logic            w_err, w_push_req, w_push, w_pop;
  logic            w_tohost_set, w_snap_load, w_wdog_fire;
  logic            w_full, w_empty;
  logic [CntW-1:0] w_count;
  logic            w_unused_be;

  assign w_unused_be = ^bus.req_be[3:1];
  assign w_accept    = bus.req_valid && (r_state == StIdle);
  assign w_in_region = (bus.req_addr[31:5] == BASE_ADDR[31:5]);
  assign w_off       = bus.req_addr[4:0];
  assign w_pop       = !w_empty && i_con_ready;
  // A push into a full FIFO only lands if the head pops in the same cycle.
  assign w_push      = w_accept && w_push_req && (!w_full || w_pop);
  assign w_wdog_fire = WdogEn && (r_cycle == WdogLast) && !r_done;

  always_comb begin
    w_rdata      = '0;
    w_err        = 1'b0;
    w_push_req   = 1'b0;
    w_tohost_set = 1'b0;
    w_snap_load  = 1'b0;
    if (!w_in_region) begin
      w_err = 1'b1;
    end else begin
      case (w_off)
        OFF_TOHOST: begin
          if (bus.req_we && bus.req_wdata[0] && !r_done) w_tohost_set = 1'b1;
        end
        OFF_CONSOLE: begin
          if (bus.req_we) begin
            if (bus.req_be[0]) begin
              w_push_req = 1'b1;
              w_err      = w_full && !w_pop;
            end
          end else begin
            w_rdata = 32'(w_count);
          end
        end
        OFF_CYCLE_LO: begin
          if (!bus.req_we) begin
            w_rdata     = r_cycle[31:0];
            w_snap_load = 1'b1;
          end
        end
        OFF_CYCLE_HI: begin
          if (!bus.req_we) w_rdata = r_snap;
        end
        OFF_STATUS: begin
          if (!bus.req_we) w_rdata = {27'b0, r_timeout, r_pass, r_done, w_full, w_empty};
        end
        default: w_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    case (r_state)
      StIdle: begin
        if (bus.req_valid) begin
          w_wait_cnt_next = '0;
          w_state_next    = (WAIT_CYCLES == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        if (r_wait_cnt == WaitLast) w_state_next = StResp;
        else                        w_wait_cnt_next = r_wait_cnt + 4'd1;
      end
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_wait_cnt <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_cycle    <= '0;
      r_snap     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_cycle    <= r_cycle + 64'd1;
      if (w_accept) begin
        r_rdata <= w_rdata;
        r_err   <= w_err;
      end
      if (w_accept && w_snap_load) r_snap <= r_cycle[63:32];
    end
  end

  // First terminating event wins; both sources are blocked once done is set.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_exit    <= '0;
      r_timeout <= 1'b0;
    end else if (w_accept && w_tohost_set) begin
      r_done <= 1'b1;
      r_pass <= (bus.req_wdata == 32'h1);
      r_exit <= bus.req_wdata[31:1];
    end else if (w_wdog_fire) begin
      r_done    <= 1'b1;
      r_pass    <= 1'b0;
      r_exit    <= EXIT_CODE_TIMEOUT;
      r_timeout <= 1'b1;
    end
  end

  sim_ctrl_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_wdata (bus.req_wdata[7:0]),
    .i_pop   (w_pop),
    .o_rdata (o_con_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.req_ready = (r_state == StIdle);
  assign bus.rsp_valid = (r_state == StResp);
  assign bus.rsp_rdata = (r_state == StResp) ? r_rdata : '0;
  assign bus.rsp_err   = (r_state == StResp) && r_err;
  assign o_con_valid   = !w_empty;
  assign o_done        = r_done;
  assign o_pass        = r_pass;
  assign o_exit_code   = r_exit;

endmodule

// File: tb/tb_sim_ctrl_slave.sv
// Directed bench for sim_ctrl_slave: a vector table of single requests plus
// hand sequences for TOHOST, console FIFO, counter, watchdog and reset abort.
module tb_sim_ctrl_slave;
  import sim_ctrl_pkg::*;

  localparam logic [31:0] B = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst, rst2;
  always #5 clk = ~clk;

  sim_ctrl_slave_if bif ();
  sim_ctrl_slave_if bif2 ();

  logic        con_valid, con_ready, done, pass;
  logic [7:0]  con_data;
  logic [30:0] exit_code;
  logic        con_valid2, done2, pass2;
  logic [7:0]  con_data2;
  logic [30:0] exit_code2;

  sim_ctrl_slave #(
    .BASE_ADDR (B), .WAIT_CYCLES (1), .FIFO_DEPTH (8), .TIMEOUT (0)
  ) dut (
    .i_clk (clk), .i_rst (rst), .bus (bif),
    .o_con_valid (con_valid), .o_con_data (con_data), .i_con_ready (con_ready),
    .o_done (done), .o_pass (pass), .o_exit_code (exit_code)
  );

  sim_ctrl_slave #(
    .BASE_ADDR (B), .WAIT_CYCLES (0), .FIFO_DEPTH (4), .TIMEOUT (100)
  ) dut_wd (
    .i_clk (clk), .i_rst (rst2), .bus (bif2),
    .o_con_valid (con_valid2), .o_con_data (con_data2), .i_con_ready (1'b0),
    .o_done (done2), .o_pass (pass2), .o_exit_code (exit_code2)
  );

  // Cycles elapsed since each reset was released.
  logic [63:0] mcycle, mcycle2;
  always @(posedge clk) begin
    if (rst) mcycle <= '0;
    else     mcycle <= mcycle + 64'd1;
    if (rst2) mcycle2 <= '0;
    else      mcycle2 <= mcycle2 + 64'd1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mkv(string nm, logic we, logic [31:0] a, logic [31:0] d,
                               logic [3:0] be, logic [31:0] er, logic ee);
    vec_t v;
    v.name = nm; v.we = we; v.addr = a; v.wdata = d; v.be = be;
    v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  // Issues one request; lat counts cycles from the accept edge to rsp_valid.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic pop, output logic [31:0] rdata,
                        output logic err, output int lat, output logic [63:0] acc);
    int n;
    @(negedge clk);
    n = 0;
    while (!bif.req_ready && n < 20) begin @(negedge clk); n++; end
    bif.req_valid = 1'b1; bif.req_we = we; bif.req_addr = addr;
    bif.req_wdata = wdata; bif.req_be = be; con_ready = pop;
    acc = mcycle;
    @(negedge clk);
    bif.req_valid = 1'b0; bif.req_we = 1'b0; con_ready = 1'b0;
    lat = 1;
    while (!bif.rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    rdata = bif.rsp_rdata;
    err   = bif.rsp_err;
  endtask

  task automatic do_req2(input logic [31:0] addr, output logic [31:0] rdata,
                         output logic err, output int lat);
    @(negedge clk);
    bif2.req_valid = 1'b1; bif2.req_we = 1'b0; bif2.req_addr = addr;
    bif2.req_wdata = '0; bif2.req_be = '0;
    @(negedge clk);
    bif2.req_valid = 1'b0;
    lat = 1;
    while (!bif2.rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    rdata = bif2.rsp_rdata;
    err   = bif2.rsp_err;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; bif.req_valid = 1'b0; con_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t        vt[15];
  logic [7:0]  exp_q[9];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    logic [63:0] acc;
    logic        seen;

    rst = 1'b1; rst2 = 1'b1; con_ready = 1'b0;
    bif.req_valid = 0; bif.req_we = 0; bif.req_addr = 0; bif.req_wdata = 0; bif.req_be = 0;
    bif2.req_valid = 0; bif2.req_we = 0; bif2.req_addr = 0; bif2.req_wdata = 0; bif2.req_be = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;

    // Watchdog instance: nobody writes TOHOST, so the timeout must end the test.
    check("wd_reset_done", done2, 0);
    n = 0;
    while (!done2 && n < 300) begin @(negedge clk); n++; end
    check("wd_done", done2, 1);
    check("wd_cycle", mcycle2, 100);
    check("wd_pass", pass2, 0);
    check("wd_exit", exit_code2, 64'h7FFF_FFFF);
    do_req2(B + 32'(OFF_STATUS), rd, er, lat);
    check("wd_status", rd, 32'h15);
    check("wd_lat", lat, 1);
    do_req2(B + 32'h14, rd, er, lat);
    check("wd_unmapped_err", er, 1);
    check("wd_unmapped_rd", rd, 0);

    // Main instance: reset state.
    apply_reset();
    check("rst_ready", bif.req_ready, 1);
    check("rst_rsp_valid", bif.rsp_valid, 0);
    check("rst_rsp_rdata", bif.rsp_rdata, 0);
    check("rst_rsp_err", bif.rsp_err, 0);
    check("rst_con_valid", con_valid, 0);
    check("rst_con_data", con_data, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_exit", exit_code, 0);

    vt[0]  = mkv("status_rst",   0, B + 32'h10, 0,            4'h0, 32'h1, 0);
    vt[1]  = mkv("unmapped_14",  0, B + 32'h14, 0,            4'h0, 32'h0, 1);
    vt[2]  = mkv("tohost_rd",    0, B + 32'h00, 0,            4'h0, 32'h0, 0);
    vt[3]  = mkv("ro_write",     1, B + 32'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0, 0);
    vt[4]  = mkv("con_be0",      1, B + 32'h04, 32'h55,       4'h0, 32'h0, 0);
    vt[5]  = mkv("con_cnt0",     0, B + 32'h04, 0,            4'h0, 32'h0, 0);
    vt[6]  = mkv("con_push",     1, B + 32'h04, 32'h5A,       4'h1, 32'h0, 0);
    vt[7]  = mkv("con_cnt1",     0, B + 32'h04, 0,            4'h0, 32'h1, 0);
    vt[8]  = mkv("status_ne",    0, B + 32'h10, 0,            4'h0, 32'h0, 0);
    vt[9]  = mkv("unmapped_1c",  0, B + 32'h1C, 0,            4'h0, 32'h0, 1);
    vt[10] = mkv("unmapped_w18", 1, B + 32'h18, 32'h1234,     4'hF, 32'h0, 1);
    vt[11] = mkv("out_region",   0, 32'h2000_0010, 0,         4'h0, 32'h0, 1);
    vt[12] = mkv("misaligned",   0, B + 32'h11, 0,            4'h0, 32'h0, 1);
    vt[13] = mkv("tohost_bit0",  1, B + 32'h00, 32'h14,       4'hF, 32'h0, 0);
    vt[14] = mkv("status_nd",    0, B + 32'h10, 0,            4'h0, 32'h0, 0);

    for (int i = 0; i < 15; i++) begin
      do_req(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, 1'b0, rd, er, lat, acc);
      check({vt[i].name, "_rdata"}, rd, vt[i].exp_rdata);
      check({vt[i].name, "_err"}, er, vt[i].exp_err);
      check({vt[i].name, "_lat"}, lat, 2);
    end
    check("tbl_con_valid", con_valid, 1);
    check("tbl_con_data", con_data, 8'h5A);
    check("tbl_done", done, 0);

    // TOHOST pass, then a later write must not change the result.
    apply_reset();
    do_req(1, B, 32'h1, 4'hF, 0, rd, er, lat, acc);
    check("pass_err", er, 0);
    check("pass_done", done, 1);
    check("pass_pass", pass, 1);
    check("pass_exit", exit_code, 0);
    do_req(1, B, 32'h15, 4'hF, 0, rd, er, lat, acc);
    check("pass2_err", er, 0);
    check("pass2_done", done, 1);
    check("pass2_pass", pass, 1);
    check("pass2_exit", exit_code, 0);
    do_req(0, B + 32'h10, 0, 0, 0, rd, er, lat, acc);
    check("pass_status", rd, 32'hD);
    do_req(0, B + 32'h08, 0, 0, 0, rd, er, lat, acc);
    check("cyc_lo", rd, {32'h0, acc[31:0]});
    do_req(0, B + 32'h0C, 0, 0, 0, rd, er, lat, acc);
    check("cyc_hi", rd, 0);
    check("cyc_hi_err", er, 0);

    // TOHOST failure code on a fresh run.
    apply_reset();
    do_req(1, B, 32'h15, 4'hF, 0, rd, er, lat, acc);
    check("fail_done", done, 1);
    check("fail_pass", pass, 0);
    check("fail_exit", exit_code, 10);

    // Nine pushes into an 8-deep FIFO with no consumer.
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      do_req(1, B + 32'h04, 32'h41 + i, 4'h1, 0, rd, er, lat, acc);
      check($sformatf("push%0d_err", i), er, (i == 8) ? 1 : 0);
    end
    do_req(0, B + 32'h04, 0, 0, 0, rd, er, lat, acc);
    check("full_count", rd, 8);
    do_req(0, B + 32'h10, 0, 0, 0, rd, er, lat, acc);
    check("full_status", rd, 32'h2);
    @(negedge clk);
    con_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain%0d_valid", k), con_valid, 1);
      check($sformatf("drain%0d_data", k), con_data, 8'h41 + k);
      @(negedge clk);
    end
    con_ready = 1'b0;
    check("drain_empty", con_valid, 0);

    // Push with a simultaneous pop while full.
    for (int i = 0; i < 8; i++) do_req(1, B + 32'h04, 32'h50 + i, 4'h1, 0, rd, er, lat, acc);
    do_req(1, B + 32'h04, 32'h60, 4'h1, 1, rd, er, lat, acc);
    check("pp_full_err", er, 0);
    do_req(0, B + 32'h04, 0, 0, 0, rd, er, lat, acc);
    check("pp_full_count", rd, 8);
    for (int i = 0; i < 7; i++) exp_q[i] = 8'h51 + 8'(i);
    exp_q[7] = 8'h60;
    @(negedge clk);
    con_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("ppdrain%0d_data", k), con_data, exp_q[k]);
      @(negedge clk);
    end
    con_ready = 1'b0;
    check("ppdrain_empty", con_valid, 0);

    // Push with the consumer ready while empty, then while partially full.
    do_req(1, B + 32'h04, 32'h70, 4'h1, 1, rd, er, lat, acc);
    check("pp_empty_err", er, 0);
    do_req(0, B + 32'h04, 0, 0, 0, rd, er, lat, acc);
    check("pp_empty_count", rd, 1);
    check("pp_empty_head", con_data, 8'h70);
    do_req(1, B + 32'h04, 32'h71, 4'h1, 1, rd, er, lat, acc);
    do_req(0, B + 32'h04, 0, 0, 0, rd, er, lat, acc);
    check("pp_part_count", rd, 1);
    check("pp_part_head", con_data, 8'h71);

    // Reset while a request is in its wait state: no response, FIFO flushed.
    @(negedge clk);
    bif.req_valid = 1'b1; bif.req_we = 1'b1; bif.req_addr = B + 32'h04;
    bif.req_wdata = 32'h33; bif.req_be = 4'h1;
    @(negedge clk);
    bif.req_valid = 1'b0;
    rst = 1'b1;
    seen = bif.rsp_valid;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      if (bif.rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_rsp", seen, 0);
    check("abort_fifo", con_valid, 0);
    check("abort_ready", bif.req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
